// File: rtl/visibility_accumulate_if.sv
// Bus bundle for visibility_accumulate: partial-sum input stream and the
// completed-visibility output stream with its framing error flag.
interface visibility_accumulate_if #(
  parameter int WIDTH = 4,
  parameter int ACCUM = 24
);
  logic             frame_i;
  logic             valid_i;
  logic [WIDTH-1:0] rdata_i;
  logic [WIDTH-1:0] idata_i;
  logic             valid_o;
  logic             first_o;
  logic             last_o;
  logic [ACCUM-1:0] rdata_o;
  logic [ACCUM-1:0] idata_o;
  logic             error_o;

  modport master (
    output frame_i, valid_i, rdata_i, idata_i,
    input  valid_o, first_o, last_o, rdata_o, idata_o, error_o
  );

  modport slave (
    input  frame_i, valid_i, rdata_i, idata_i,
    output valid_o, first_o, last_o, rdata_o, idata_o, error_o
  );
endinterface

// File: rtl/visibility_accumulate.sv
// Accumulates per-slot correlator partial sums over COUNT frames and streams
// the completed visibilities out during the last frame of each accumulation.
module visibility_accumulate #(
  parameter int WIDTH = 4,
  parameter int ACCUM = 24,
  parameter int SBITS = 3,
  parameter int CBITS = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  visibility_accumulate_if.slave bus
);
  localparam int               NSLOTS = 1 << SBITS;
  localparam logic [SBITS:0]   SFULL  = (SBITS+1)'(NSLOTS);
  localparam logic [CBITS-1:0] FLAST  = '1;

  logic [SBITS:0]   s_q, s_d;
  logic [CBITS-1:0] f_q, f_d;
  logic             frame_q;
  logic             error_q, error_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [ACCUM-1:0] rdata_q, rdata_d;
  logic [ACCUM-1:0] idata_q, idata_d;
  logic [ACCUM-1:0] racc_q [NSLOTS];
  logic [ACCUM-1:0] iacc_q [NSLOTS];

  logic [SBITS-1:0] slot;
  logic [ACCUM-1:0] rext, iext;
  logic             accept, in_range, fall, acc_we;

  assign slot     = s_q[SBITS-1:0];
  assign rext     = ACCUM'(bus.rdata_i);
  assign iext     = ACCUM'(bus.idata_i);
  assign accept   = bus.valid_i && bus.frame_i;
  assign in_range = !s_q[SBITS];
  assign fall     = frame_q && !bus.frame_i;
  // The final frame of an accumulation feeds the output path instead of the array.
  assign acc_we   = accept && in_range && (f_q != FLAST);

  always_comb begin
    // NOTE: every _d gets a default first, so no path can leave it unassigned and infer a latch.
    s_d     = s_q;
    f_d     = f_q;
    error_d = error_q;
    valid_d = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    rdata_d = rdata_q;
    idata_d = idata_q;

    if (bus.valid_i && !bus.frame_i) error_d = 1'b1;

    if (accept) begin
      if (in_range) begin
        s_d = s_q + 1'b1;
        if (f_q == FLAST) begin
          valid_d = 1'b1;
          first_d = (slot == '0);
          last_d  = (slot == SBITS'(NSLOTS - 1));
          rdata_d = racc_q[slot] + rext;
          idata_d = iacc_q[slot] + iext;
        end
      end else begin
        error_d = 1'b1;
      end
    end

    // A falling edge implies frame_i low, so it never coincides with an accepted sample.
    if (fall) begin
      s_d = '0;
      if (s_q == SFULL) f_d = f_q + 1'b1;
      else              error_d = 1'b1;
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= '0;
      f_q     <= '0;
      frame_q <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      idata_q <= '0;
    end else begin
      s_q     <= s_d;
      f_q     <= f_d;
      frame_q <= bus.frame_i;
      error_q <= error_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      idata_q <= idata_d;
    end
  end

  // NOTE: the accumulator arrays carry no reset; frame f==0 overwrites every slot before use.
  always_ff @(posedge clock) begin
    if (acc_we) begin
      racc_q[slot] <= (f_q == '0) ? rext : racc_q[slot] + rext;
      iacc_q[slot] <= (f_q == '0) ? iext : iacc_q[slot] + iext;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.first_o = first_q;
  assign bus.last_o  = last_q;
  assign bus.rdata_o = rdata_q;
  assign bus.idata_o = idata_q;
  assign bus.error_o = error_q;
endmodule

// File: tb/tb_visibility_accumulate.sv
// Randomized scoreboard bench for visibility_accumulate (NSLOTS=4, COUNT=4)
// plus a second instance at WIDTH=4, CBITS=4, ACCUM=8 for the no-wrap bound.
module tb_visibility_accumulate;
  localparam int NS  = 4;
  localparam int CNT = 4;

  typedef struct {
    int r;
    int i;
    bit first;
    bit last;
  } beat_t;

  logic clock;
  logic reset_n;
  logic reset_b_n;

  visibility_accumulate_if #(.WIDTH(4), .ACCUM(24)) bus_a ();
  visibility_accumulate_if #(.WIDTH(4), .ACCUM(8))  bus_b ();

  visibility_accumulate #(.WIDTH(4), .ACCUM(24), .SBITS(2), .CBITS(2)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_a)
  );

  visibility_accumulate #(.WIDTH(4), .ACCUM(8), .SBITS(3), .CBITS(4)) dut_b (
    .clock  (clock),
    .reset_n(reset_b_n),
    .bus    (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];

  // Reference model: accumulation phase, samples seen in the current frame, running totals.
  int phase   = 0;
  int nsample = 0;
  bit exp_err = 1'b0;
  int tot_r[NS];
  int tot_i[NS];
  int vr[8];
  int vi[8];
  bit done_b = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_sample(input int r, input int i);
    int k;
    if (nsample >= NS) begin
      exp_err = 1'b1;
      return;
    end
    k = nsample;
    nsample++;
    if (phase == 0) begin
      tot_r[k] = r;
      tot_i[k] = i;
    end else if (phase == CNT - 1) begin
      exp_q.push_back('{r: tot_r[k] + r, i: tot_i[k] + i, first: (k == 0), last: (k == NS - 1)});
    end else begin
      tot_r[k] += r;
      tot_i[k] += i;
    end
  endfunction

  function automatic void model_frame_end();
    if (nsample == NS) phase = (phase + 1) % CNT;
    else               exp_err = 1'b1;
    nsample = 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit fr, input bit v, input int r, input int i);
    bus_a.frame_i = fr;
    bus_a.valid_i = v;
    bus_a.rdata_i = 4'(r);
    bus_a.idata_i = 4'(i);
    if (fr && v)  model_sample(r, i);
    if (!fr && v) exp_err = 1'b1;
    tick();
  endtask

  task automatic send_frame(input int n, input int gap_pct);
    for (int j = 0; j < n; j++) begin
      if (j > 0 && $urandom_range(0, 99) < gap_pct) drive(1'b1, 1'b0, 0, 0);
      drive(1'b1, 1'b1, vr[j], vi[j]);
    end
    drive(1'b0, 1'b0, 0, 0);
    model_frame_end();
    check("error_after_frame", bus_a.error_o, exp_err);
    repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic fill_const(input int r, input int i);
    for (int j = 0; j < 8; j++) begin
      vr[j] = r;
      vi[j] = i;
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < 8; j++) begin
      vr[j] = $urandom_range(0, 15);
      vi[j] = $urandom_range(0, 15);
    end
  endtask

  // Monitor: pops the scoreboard on every output beat, checks hold/zero otherwise.
  int last_r = 0;
  int last_i = 0;
  always @(negedge clock) begin
    if (!reset_n) begin
      check("reset_outputs",
            {bus_a.valid_o, bus_a.first_o, bus_a.last_o, bus_a.error_o, bus_a.rdata_o, bus_a.idata_o},
            64'd0);
      last_r = 0;
      last_i = 0;
    end else if (bus_a.valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got rdata %0d idata %0d, required no beat", bus_a.rdata_o,
                 bus_a.idata_o);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("rdata", bus_a.rdata_o, 64'(e.r));
        check("idata", bus_a.idata_o, 64'(e.i));
        check("first", bus_a.first_o, 64'(e.first));
        check("last", bus_a.last_o, 64'(e.last));
      end
      last_r = int'(bus_a.rdata_o);
      last_i = int'(bus_a.idata_o);
    end else begin
      check("hold", {bus_a.first_o, bus_a.last_o, bus_a.rdata_o, bus_a.idata_o},
            {2'b00, 24'(last_r), 24'(last_i)});
    end
  end

  // Saturation bound instance: 16 frames of all-15 samples must give 240 in an 8-bit total.
  int beats_b = 0;
  always @(negedge clock) begin
    if (reset_b_n && bus_b.valid_o) begin
      beats_b++;
      check("sat_rdata", bus_b.rdata_o, 64'd240);
      check("sat_idata", bus_b.idata_o, 64'd240);
    end
  end

  initial begin
    reset_b_n     = 1'b0;
    bus_b.frame_i = 1'b0;
    bus_b.valid_i = 1'b0;
    bus_b.rdata_i = 4'd15;
    bus_b.idata_i = 4'd15;
    repeat (3) tick();
    reset_b_n = 1'b1;
    tick();
    for (int fr = 0; fr < 16; fr++) begin
      for (int k = 0; k < 8; k++) begin
        bus_b.frame_i = 1'b1;
        bus_b.valid_i = 1'b1;
        tick();
      end
      bus_b.frame_i = 1'b0;
      bus_b.valid_i = 1'b0;
      tick();
    end
    repeat (3) tick();
    check("sat_beats", beats_b, 64'd8);
    check("sat_error", bus_b.error_o, 64'd0);
    done_b = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus_a.frame_i = 1'b0;
    bus_a.valid_i = 1'b0;
    bus_a.rdata_i = '0;
    bus_a.idata_i = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_error", bus_a.error_o, 64'd0);

    // Four clean frames of 3/5: the fourth frame emits 12/20 on every slot.
    fill_const(3, 5);
    repeat (CNT) send_frame(NS, 0);

    // Ramp slot k = k+1, back-to-back, then a restart with all-ones.
    for (int j = 0; j < 8; j++) begin
      vr[j] = j + 1;
      vi[j] = 2 * (j + 1);
    end
    repeat (CNT) send_frame(NS, 0);
    fill_const(1, 1);
    repeat (CNT) send_frame(NS, 0);

    // Random values with random in-frame gaps.
    repeat (3 * CNT) begin
      fill_random();
      send_frame(NS, 30);
    end
    check("clean_error", bus_a.error_o, 64'd0);

    // Short frame: sticky error, phase unchanged.
    fill_random();
    send_frame(NS - 1, 0);
    check("short_error", bus_a.error_o, 64'd1);

    // Stray sample between frames.
    drive(1'b0, 1'b1, 9, 9);
    check("stray_error", bus_a.error_o, 64'd1);

    // Long frame: the extra sample is dropped.
    fill_random();
    send_frame(NS + 1, 0);

    repeat (2 * CNT) begin
      fill_random();
      send_frame(NS, 20);
    end
    check("error_sticky", bus_a.error_o, 64'd1);

    // Reset during frame 2 of 4, then four clean frames of 2 give 8.
    while (phase != 1) begin
      fill_random();
      send_frame(NS, 0);
    end
    drive(1'b1, 1'b1, 7, 7);
    bus_a.frame_i = 1'b1;
    bus_a.valid_i = 1'b1;
    reset_n = 1'b0;
    #1;
    bus_a.frame_i = 1'b0;
    bus_a.valid_i = 1'b0;
    check("pending_before_reset", exp_q.size(), 64'd0);
    phase   = 0;
    nsample = 0;
    exp_err = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("reset_clears_error", bus_a.error_o, 64'd0);
    check("reset_clears_data", {bus_a.rdata_o, bus_a.idata_o}, 64'd0);
    fill_const(2, 2);
    repeat (CNT) send_frame(NS, 0);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 64'd0);
    for (int t = 0; t < 2000 && !done_b; t++) tick();
    check("sat_done", done_b, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/visibility_accumulate.md
# visibility_accumulate

Long-term visibility accumulator downstream of the 1-bit correlator lanes. It takes the short, WIDTH-bit partial sums each correlator emits once per correlation window. Those sums arrive time-multiplexed as NSLOTS baseline slots per frame. The block adds them into ACCUM-bit per-slot totals over COUNT consecutive frames, then streams the completed visibilities out.

## Interface
Parameters:
- WIDTH, 4: bit-width of incoming partial sums (matches correlator WIDTH).
- ACCUM, 24: bit-width of accumulators and output data; must be ≥ WIDTH+CBITS.
- SBITS, 3: slot index width; NSLOTS = 2**SBITS slots per frame.
- CBITS, 4: frame counter width; COUNT = 2**CBITS frames per accumulation.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_i  in  1  high while a frame of partial sums is being delivered.
- valid_i  in  1  one partial-sum pair present this cycle.
- rdata_i  in  WIDTH  real partial sum, unsigned.
- idata_i  in  WIDTH  imaginary partial sum, unsigned.
- valid_o  out  1  completed visibility present.
- first_o  out  1  marks slot 0 of an output frame.
- last_o  out  1  marks slot NSLOTS-1 of an output frame.
- rdata_o  out  ACCUM  accumulated real total, unsigned.
- idata_o  out  ACCUM  accumulated imaginary total, unsigned.
- error_o  out  1  sticky framing error flag.

## Operation
- State:
  - slot counter `s` (SBITS+1 bits);
  - frame counter `f` (CBITS bits);
  - registered copy of frame_i for edge detection;
  - accumulator arrays racc/iacc of NSLOTS×ACCUM. These arrays are not reset; the first frame overwrites them.
- Accepted sample: valid_i && frame_i. It targets slot s[SBITS-1:0], then s increments.
  - f == 0: acc[s] <= zero-extended input (restart).
  - 0 < f < COUNT-1: acc[s] <= acc[s] + zero-extended input.
  - f == COUNT-1: the output registers get acc[s] + input and valid_o is asserted. acc[s] is not written.
- Frame end: frame_i falling edge (registered frame high, frame_i low).
  - s == NSLOTS: f <= f+1, wrapping COUNT-1 → 0. s <= 0.
  - s != NSLOTS (short frame): error_o <= 1, s <= 0, f unchanged. Slots written in that frame are discarded. f == 0 next time restarts them; otherwise they are over-counted, which error_o flags.
- Long frame: an accepted sample with s == NSLOTS is dropped and sets error_o; the frame end then also counts as bad.
- Stray sample: valid_i with frame_i low is ignored and sets error_o.
- Sample and falling edge in the same cycle cannot occur when frame_i is low. A sample and a rising edge together is normal: the sample is accepted as slot 0.
- Output flags: first_o = (slot == 0), last_o = (slot == NSLOTS-1). Both are qualified by valid_o and low otherwise.
- Arithmetic: unsigned, no saturation. Parameter rule ACCUM ≥ WIDTH+CBITS guarantees no overflow. Offset-encoded bias removal is done downstream.

## Timing
- Reset (async assert, sync-safe release): valid_o=0, first_o=0, last_o=0, rdata_o=0, idata_o=0, error_o=0. s=0, f=0, registered frame=0.
- Latency: accepted sample at edge N gives output valid_o/data at edge N+1, for one cycle per sample.
- Throughput: one sample per clock sustained. No backpressure; the consumer must accept every valid_o.
- Output data holds its last value when valid_o=0.
- Reset mid-accumulation: the partial totals are abandoned. After release, the next frame starts with f=0 and overwrites them.
- error_o clears only on reset.

## Test plan
- NSLOTS=4, COUNT=4, four clean frames with every sample rdata_i=3, idata_i=5. Required: four valid_o beats in frame 4 with rdata_o=12, idata_o=20; first_o on beat 1, last_o on beat 4; error_o=0.
- Slot-distinct ramp: slot k value k+1, back-to-back valid every cycle, COUNT frames. Required: output slot k = COUNT·(k+1). A following COUNT frames of value 1 give exactly COUNT, proving the restart.
- Saturation bound: WIDTH=4, CBITS=4, all inputs 15 for 16 frames. Required: every output equals 240, with no wrap.
- Short frame: frame with NSLOTS-1 samples. Required: error_o=1 next cycle and remains 1. f is unchanged; the next clean frame starts at slot 0.
- Stray sample: valid_i=1 while frame_i=0. Required: no accumulator or output change, error_o=1.
- Reset asserted mid-frame 2 of 4, then four clean frames of value 2. Required: all outputs are 0 during and just after reset; the first output frame has totals of 8.
